// File: rtl/life_pkg.sv
// Shared types and constants for the Game of Life generation scheduler:
// engine state encoding, default board size and the 3x3 neighbour offset table.
package life_pkg;

   localparam int GRID_W_DEF = 8;
   localparam int GRID_H_DEF = 8;
   localparam int NBR_READS  = 9;

   typedef enum logic [2:0] {
      ST_WAIT  = 3'd0,
      ST_FETCH = 3'd1,
      ST_EVAL  = 3'd2,
      ST_WRITE = 3'd3,
      ST_DONE  = 3'd4
   } life_state_e;

   // Two's-complement row/column step in the range -1..+1.
   typedef struct packed {
      logic [1:0] dr;
      logic [1:0] dc;
   } nbr_ofs_t;

   localparam logic [1:0] OFS_M1 = 2'b11;
   localparam logic [1:0] OFS_Z0 = 2'b00;
   localparam logic [1:0] OFS_P1 = 2'b01;

   // Read k=0 is the cell itself; k=1..8 walk the ring row by row.
   function automatic nbr_ofs_t nbr_offset(input logic [3:0] k);
      nbr_ofs_t o;
      o = '{dr: OFS_Z0, dc: OFS_Z0};
      case (k)
         4'd1:    o = '{dr: OFS_M1, dc: OFS_M1};
         4'd2:    o = '{dr: OFS_M1, dc: OFS_Z0};
         4'd3:    o = '{dr: OFS_M1, dc: OFS_P1};
         4'd4:    o = '{dr: OFS_Z0, dc: OFS_M1};
         4'd5:    o = '{dr: OFS_Z0, dc: OFS_P1};
         4'd6:    o = '{dr: OFS_P1, dc: OFS_M1};
         4'd7:    o = '{dr: OFS_P1, dc: OFS_Z0};
         4'd8:    o = '{dr: OFS_P1, dc: OFS_P1};
         default: o = '{dr: OFS_Z0, dc: OFS_Z0};
      endcase
      return o;
   endfunction

endpackage

// File: rtl/life_nbr_addr.sv
// Combinational (cell, k) -> toroidally wrapped board address.
// Wrap-around comes for free from truncating row/col to their field widths.
module life_nbr_addr
   import life_pkg::*;
#(
   parameter int GRID_W = GRID_W_DEF,
   parameter int GRID_H = GRID_H_DEF,
   localparam int COL_W = $clog2(GRID_W),
   localparam int ROW_W = $clog2(GRID_H),
   localparam int ADDR_W = ROW_W + COL_W
) (
   input  logic [ADDR_W-1:0] cell_i,
   input  logic [3:0]        k_i,
   output logic [ADDR_W-1:0] addr_o
);

   nbr_ofs_t         ofs;
   logic [ROW_W-1:0] row, row_n, dr_ext;
   logic [COL_W-1:0] col, col_n, dc_ext;

   always_comb begin
      ofs    = nbr_offset(k_i);
      row    = cell_i[ADDR_W-1:COL_W];
      col    = cell_i[COL_W-1:0];
      // Sign-extend the 2-bit step so -1 becomes all ones in the field.
      dr_ext = {{(ROW_W-1){ofs.dr[1]}}, ofs.dr[0]};
      dc_ext = {{(COL_W-1){ofs.dc[1]}}, ofs.dc[0]};
      row_n  = row + dr_ext;
      col_n  = col + dc_ext;
      addr_o = {row_n, col_n};
   end

endmodule

// File: rtl/life_gen_scheduler.sv
// Runs one Game of Life generation per triggering idle window, sharing the single
// memory read port with the display fetch and swapping banks once a generation completes.
module life_gen_scheduler
   import life_pkg::*;
#(
   parameter int GRID_W     = GRID_W_DEF,
   parameter int GRID_H     = GRID_H_DEF,
   parameter int ADDR_W     = $clog2(GRID_W*GRID_H),
   parameter int GEN_PERIOD = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              idle,
   input  logic              run,
   input  logic              step_req,
   input  logic [ADDR_W-1:0] disp_addr,
   output logic [ADDR_W-1:0] rd_addr,
   output logic              rd_bank,
   input  logic              rd_data,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic              wr_bank,
   output logic              wr_data,
   output logic              front_bank,
   output logic              busy,
   output logic [15:0]       gen_count,
   output logic              overrun,
   output life_state_e       dbg_state
);

   localparam int                DIV_W     = (GEN_PERIOD > 1) ? $clog2(GEN_PERIOD) : 1;
   localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(GEN_PERIOD - 1);
   localparam logic [ADDR_W-1:0] CELL_LAST = ADDR_W'(GRID_W*GRID_H - 1);
   localparam logic [3:0]        K_LAST    = 4'(NBR_READS - 1);

   life_state_e       state_q, state_d;
   logic [3:0]        k_q, k_d;
   logic [ADDR_W-1:0] cell_q, cell_d;
   logic              self_q, self_d;
   logic [3:0]        nbr_q, nbr_d;
   logic              front_q, front_d;
   logic [15:0]       gen_cnt_q, gen_cnt_d;
   logic              overrun_q, overrun_d;
   logic [DIV_W-1:0]  gen_div_q, gen_div_d;
   logic              step_pend_q, step_pend_d;
   logic              idle_q;

   logic              idle_rise, idle_fall, busy_w, start, eng_sel;
   logic [ADDR_W-1:0] eng_addr;

   life_nbr_addr #(
      .GRID_W (GRID_W),
      .GRID_H (GRID_H)
   ) u_nbr_addr (
      .cell_i (cell_q),
      .k_i    (k_q),
      .addr_o (eng_addr)
   );

   always_comb begin
      idle_rise   = idle & ~idle_q;
      idle_fall   = ~idle & idle_q;
      busy_w      = (state_q == ST_FETCH) || (state_q == ST_EVAL) || (state_q == ST_WRITE);
      start       = 1'b0;
      gen_div_d   = gen_div_q;
      step_pend_d = step_pend_q;

      // Triggers are only honoured in WAIT; a pending step survives busy windows.
      if ((state_q == ST_WAIT) && idle_rise) begin
         if (step_pend_q) begin
            start       = 1'b1;
            step_pend_d = 1'b0;
         end else if (run) begin
            if (gen_div_q == DIV_LAST) begin
               start     = 1'b1;
               gen_div_d = '0;
            end else begin
               gen_div_d = gen_div_q + 1'b1;
            end
         end
      end
      if (step_req) begin
         step_pend_d = 1'b1;
      end
   end

   always_comb begin
      state_d   = state_q;
      k_d       = k_q;
      cell_d    = cell_q;
      self_d    = self_q;
      nbr_d     = nbr_q;
      front_d   = front_q;
      gen_cnt_d = gen_cnt_q;
      overrun_d = 1'b0;

      case (state_q)
         ST_WAIT: begin
            if (start) begin
               state_d = ST_FETCH;
               cell_d  = '0;
               k_d     = '0;
               nbr_d   = '0;
            end
         end
         ST_FETCH: begin
            // rd_data lags the address by one cycle, so here it carries read k-1.
            if (k_q == 4'd1) begin
               self_d = rd_data;
            end else if (k_q >= 4'd2) begin
               nbr_d = nbr_q + {3'b000, rd_data};
            end
            if (k_q == K_LAST) begin
               state_d = ST_EVAL;
            end else begin
               k_d = k_q + 4'd1;
            end
         end
         ST_EVAL: begin
            nbr_d   = nbr_q + {3'b000, rd_data};
            state_d = ST_WRITE;
         end
         ST_WRITE: begin
            if (cell_q == CELL_LAST) begin
               state_d = ST_DONE;
            end else begin
               state_d = ST_FETCH;
               cell_d  = cell_q + 1'b1;
               k_d     = '0;
               nbr_d   = '0;
            end
         end
         ST_DONE: begin
            if (idle_fall) begin
               front_d   = ~front_q;
               gen_cnt_d = gen_cnt_q + 16'd1;
               state_d   = ST_WAIT;
            end
         end
         default: state_d = ST_WAIT;
      endcase

      if (busy_w && idle_fall) begin
         state_d   = ST_WAIT;
         overrun_d = 1'b1;
      end
   end

   always_ff @(negedge clk) begin
      if (rst) begin
         state_q     <= ST_WAIT;
         k_q         <= '0;
         cell_q      <= '0;
         self_q      <= 1'b0;
         nbr_q       <= '0;
         front_q     <= 1'b0;
         gen_cnt_q   <= '0;
         overrun_q   <= 1'b0;
         gen_div_q   <= '0;
         step_pend_q <= 1'b0;
         idle_q      <= 1'b1;
      end else begin
         state_q     <= state_d;
         k_q         <= k_d;
         cell_q      <= cell_d;
         self_q      <= self_d;
         nbr_q       <= nbr_d;
         front_q     <= front_d;
         gen_cnt_q   <= gen_cnt_d;
         overrun_q   <= overrun_d;
         gen_div_q   <= gen_div_d;
         step_pend_q <= step_pend_d;
         idle_q      <= idle;
      end
   end

   // The engine only owns the read port while the LEDs are not being fed.
   assign eng_sel    = ((state_q == ST_FETCH) || (state_q == ST_EVAL)) && idle;
   assign rd_addr    = eng_sel ? eng_addr : disp_addr;
   assign rd_bank    = front_q;

   assign wr_en      = (state_q == ST_WRITE) && idle && !rst;
   assign wr_addr    = cell_q;
   assign wr_bank    = ~front_q;
   assign wr_data    = (nbr_q == 4'd3) | (self_q & (nbr_q == 4'd2));

   assign front_bank = front_q;
   assign busy       = busy_w;
   assign gen_count  = gen_cnt_q;
   assign overrun    = overrun_q;
   assign dbg_state  = state_q;

endmodule

// File: tb/tb_life_gen_scheduler.sv
// Bench for life_gen_scheduler: table of board patterns with hand-derived next generations,
// plus overrun, single-step, generation-period, read-mux and mid-generation reset sequences.
module tb_life_gen_scheduler;
   import life_pkg::*;

   localparam int AW = 6;

   typedef struct {
      logic [63:0] init;
      logic [63:0] next;
   } vec_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // DUT A: GEN_PERIOD=1
   logic          rst_a, idle_a, run_a, step_a;
   logic [AW-1:0] disp_addr;
   logic [AW-1:0] rd_addr_a, wr_addr_a;
   logic          rd_bank_a, rd_data_a, wr_en_a, wr_bank_a, wr_data_a;
   logic          front_a, busy_a, overrun_a;
   logic [15:0]   gen_a;
   life_state_e   dbg_a;

   // DUT B: GEN_PERIOD=4
   logic          rst_b, idle_b, run_b, step_b;
   logic [AW-1:0] rd_addr_b, wr_addr_b;
   logic          rd_bank_b, rd_data_b, wr_en_b, wr_bank_b, wr_data_b;
   logic          front_b, busy_b, overrun_b;
   logic [15:0]   gen_b;
   life_state_e   dbg_b;

   life_gen_scheduler #(.GRID_W(8), .GRID_H(8), .ADDR_W(AW), .GEN_PERIOD(1)) dut_a (
      .clk(clk), .rst(rst_a), .idle(idle_a), .run(run_a), .step_req(step_a),
      .disp_addr(disp_addr), .rd_addr(rd_addr_a), .rd_bank(rd_bank_a), .rd_data(rd_data_a),
      .wr_en(wr_en_a), .wr_addr(wr_addr_a), .wr_bank(wr_bank_a), .wr_data(wr_data_a),
      .front_bank(front_a), .busy(busy_a), .gen_count(gen_a), .overrun(overrun_a),
      .dbg_state(dbg_a)
   );

   life_gen_scheduler #(.GRID_W(8), .GRID_H(8), .ADDR_W(AW), .GEN_PERIOD(4)) dut_b (
      .clk(clk), .rst(rst_b), .idle(idle_b), .run(run_b), .step_req(step_b),
      .disp_addr(disp_addr), .rd_addr(rd_addr_b), .rd_bank(rd_bank_b), .rd_data(rd_data_b),
      .wr_en(wr_en_b), .wr_addr(wr_addr_b), .wr_bank(wr_bank_b), .wr_data(wr_data_b),
      .front_bank(front_b), .busy(busy_b), .gen_count(gen_b), .overrun(overrun_b),
      .dbg_state(dbg_b)
   );

   // Ping-pong memory models, index {bank, addr}; read data one cycle after the address.
   logic [127:0] mem_a, mem_b, ld_img;
   logic         ld_en_a, ld_en_b;
   int           wr_cnt_a = 0;
   int           viol_a = 0;

   always @(negedge clk) begin
      rd_data_a <= mem_a[{rd_bank_a, rd_addr_a}];
      if (ld_en_a) mem_a <= ld_img;
      else if (wr_en_a) mem_a[{wr_bank_a, wr_addr_a}] <= wr_data_a;
      if (wr_en_a) wr_cnt_a <= wr_cnt_a + 1;
      if (wr_en_a && !idle_a) viol_a <= viol_a + 1;
   end

   always @(negedge clk) begin
      rd_data_b <= mem_b[{rd_bank_b, rd_addr_b}];
      if (ld_en_b) mem_b <= ld_img;
      else if (wr_en_b) mem_b[{wr_bank_b, wr_addr_b}] <= wr_data_b;
   end

   // Scoreboard state
   logic [63:0] exp_q[$];
   logic        exp_front;
   logic [15:0] exp_gen;
   int          n_vec = 0;
   int          n_err = 0;
   vec_t        vecs [8];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [63:0] bank_of(input logic [127:0] m, input logic b);
      return b ? m[127:64] : m[63:0];
   endfunction

   // Loads the pattern into the current front bank and junk into the back bank.
   task automatic load_a(input logic [63:0] pat);
      logic [63:0] junk;
      junk    = {$urandom(), $urandom()};
      ld_img  = exp_front ? {pat, junk} : {junk, pat};
      ld_en_a = 1'b1;
      @(posedge clk);
      ld_en_a = 1'b0;
   endtask

   task automatic window_a(input string tag, input int len, input bit exp_swap,
                           input logic [63:0] exp_board, input int exp_writes);
      logic f0;
      int   w0;
      bit   seen;
      f0 = front_a;
      w0 = wr_cnt_a;
      if (exp_swap) exp_q.push_back(exp_board);
      idle_a = 1'b1;
      repeat (len) @(posedge clk);
      idle_a = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 4 && !seen; i++) begin
         @(posedge clk);
         if (front_a !== f0) seen = 1'b1;
      end
      check({tag, " swap"}, 64'(seen), 64'(exp_swap));
      if (seen && exp_q.size() > 0)
         check({tag, " board"}, bank_of(mem_a, front_a), exp_q.pop_front());
      else if (!seen && exp_swap)
         void'(exp_q.pop_front());
      if (exp_swap) begin
         exp_front = ~exp_front;
         exp_gen   = exp_gen + 16'd1;
      end
      check({tag, " front_bank"}, 64'(front_a), 64'(exp_front));
      check({tag, " gen_count"}, 64'(gen_a), 64'(exp_gen));
      if (exp_writes >= 0)
         check({tag, " write count"}, 64'(wr_cnt_a - w0), 64'(exp_writes));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL timeout: simulation exceeded its time limit");
      $fatal(1);
   end

   initial begin
      int ov;
      bit got;

      vecs[0] = '{init: (64'd1 << 26) | (64'd1 << 27) | (64'd1 << 28),
                  next: (64'd1 << 19) | (64'd1 << 27) | (64'd1 << 35)};
      vecs[1] = '{init: (64'd1 << 0) | (64'd1 << 7) | (64'd1 << 56) | (64'd1 << 63),
                  next: (64'd1 << 0) | (64'd1 << 7) | (64'd1 << 56) | (64'd1 << 63)};
      vecs[2] = '{init: (64'd1 << 9) | (64'd1 << 10) | (64'd1 << 17) | (64'd1 << 18),
                  next: (64'd1 << 9) | (64'd1 << 10) | (64'd1 << 17) | (64'd1 << 18)};
      vecs[3] = '{init: (64'd1 << 27), next: 64'd0};
      vecs[4] = '{init: (64'd1 << 1) | (64'd1 << 10) | (64'd1 << 16) | (64'd1 << 17) | (64'd1 << 18),
                  next: (64'd1 << 8) | (64'd1 << 10) | (64'd1 << 17) | (64'd1 << 18) | (64'd1 << 25)};
      vecs[5] = '{init: (64'd1 << 56) | (64'd1 << 0) | (64'd1 << 8),
                  next: (64'd1 << 7) | (64'd1 << 0) | (64'd1 << 1)};
      vecs[6] = '{init: {64{1'b1}}, next: 64'd0};
      vecs[7] = '{init: 64'd0, next: 64'd0};

      // Clock/reset block: idle held high through reset must not trigger afterwards.
      rst_a = 1'b1; idle_a = 1'b1; run_a = 1'b1; step_a = 1'b0;
      rst_b = 1'b1; idle_b = 1'b1; run_b = 1'b1; step_b = 1'b0;
      disp_addr = '0; ld_img = '0; ld_en_a = 1'b1; ld_en_b = 1'b1;
      exp_front = 1'b0; exp_gen = 16'd0;
      repeat (3) @(posedge clk);
      ld_en_a = 1'b0; ld_en_b = 1'b0;
      rst_a = 1'b0; rst_b = 1'b0;
      repeat (10) @(posedge clk);
      check("reset busy (idle already high)", 64'(busy_a), 64'd0);
      check("reset front_bank", 64'(front_a), 64'd0);
      check("reset gen_count", 64'(gen_a), 64'd0);
      check("reset wr_en", 64'(wr_en_a), 64'd0);
      check("reset overrun", 64'(overrun_a), 64'd0);
      check("reset state", 64'(dbg_a), 64'(ST_WAIT));
      check("reset busy B", 64'(busy_b), 64'd0);
      idle_a = 1'b0; idle_b = 1'b0;
      repeat (2) @(posedge clk);

      // Display owns the read port while idle is low.
      for (int i = 0; i < 16; i++) begin
         disp_addr = AW'($urandom_range(0, 63));
         @(posedge clk);
         check($sformatf("mux rd_addr %0d", i), 64'(rd_addr_a), 64'(disp_addr));
         check($sformatf("mux rd_bank %0d", i), 64'(rd_bank_a), 64'(exp_front));
      end

      // Table of patterns, one full generation each.
      for (int v = 0; v < 8; v++) begin
         load_a(vecs[v].init);
         window_a($sformatf("vec%0d", v), 720, 1'b1, vecs[v].next, 64);
      end

      // Overrun: window too short for a generation.
      load_a(vecs[0].init);
      idle_a = 1'b1;
      repeat (300) @(posedge clk);
      check("overrun busy mid-window", 64'(busy_a), 64'd1);
      idle_a = 1'b0;
      ov = 0;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk);
         ov += int'(overrun_a);
      end
      check("overrun pulse count", 64'(ov), 64'd1);
      check("overrun front_bank", 64'(front_a), 64'(exp_front));
      check("overrun gen_count", 64'(gen_a), 64'(exp_gen));
      check("overrun busy after", 64'(busy_a), 64'd0);
      window_a("post-overrun", 720, 1'b1, vecs[0].next, 64);

      // Single step with run=0.
      run_a = 1'b0;
      window_a("run0 idle", 720, 1'b0, 64'd0, 0);
      load_a(vecs[4].init);
      step_a = 1'b1;
      @(posedge clk);
      step_a = 1'b0;
      repeat (2) @(posedge clk);
      window_a("step", 720, 1'b1, vecs[4].next, 64);
      window_a("after step", 720, 1'b0, 64'd0, 0);

      // Generation period 4 on DUT B: swaps only after windows 4 and 8.
      for (int w = 1; w <= 8; w++) begin
         idle_b = 1'b1;
         repeat (720) @(posedge clk);
         idle_b = 1'b0;
         repeat (4) @(posedge clk);
         check($sformatf("period w%0d gen_count", w), 64'(gen_b), 64'(w / 4));
         check($sformatf("period w%0d front_bank", w), 64'(front_b), 64'((w / 4) % 2));
      end
      check("period overrun", 64'(overrun_b), 64'd0);
      check("period state", 64'(dbg_b), 64'(ST_WAIT));

      // Reset asserted mid-FETCH.
      run_a = 1'b1;
      load_a(vecs[1].init);
      idle_a = 1'b1;
      got = 1'b0;
      for (int i = 0; i < 10 && !got; i++) begin
         @(posedge clk);
         if (dbg_a == ST_FETCH) got = 1'b1;
      end
      check("reached FETCH", 64'(got), 64'd1);
      repeat (3) @(posedge clk);
      rst_a = 1'b1;
      @(posedge clk);
      check("mid-reset wr_en", 64'(wr_en_a), 64'd0);
      check("mid-reset busy", 64'(busy_a), 64'd0);
      check("mid-reset front_bank", 64'(front_a), 64'd0);
      check("mid-reset gen_count", 64'(gen_a), 64'd0);
      check("mid-reset overrun", 64'(overrun_a), 64'd0);
      rst_a = 1'b0;
      exp_front = 1'b0;
      exp_gen   = 16'd0;
      repeat (5) @(posedge clk);
      check("post-reset no trigger", 64'(busy_a), 64'd0);
      idle_a = 1'b0;
      repeat (2) @(posedge clk);
      load_a(vecs[1].init);
      window_a("post-reset", 720, 1'b1, vecs[1].next, 64);

      check("wr_en outside idle", 64'(viol_a), 64'd0);
      check("scoreboard drained", 64'(exp_q.size()), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
